// File: rtl/reg_write_arbiter.sv
// Two-source register-file write arbiter: one holding buffer per requester,
// round-robin issue of one write per cycle, and a per-register pending scoreboard.
module reg_write_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          WE3,
   output logic [AW-1:0] A3,
   output logic [DW-1:0] WD3,
   output logic          grant_src,
   output logic [31:0]   pending
);

   typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

   src_t          rr_ptr, rr_ptr_n;
   logic          alu_full, alu_full_n, mem_full, mem_full_n;
   logic [AW-1:0] alu_baddr, mem_baddr;
   logic [DW-1:0] alu_bdata, mem_bdata;
   logic          alu_acc, mem_acc, grant_alu, grant_mem;
   logic          we_n, gsrc_n;
   logic [AW-1:0] a_n;
   logic [DW-1:0] wd_n;
   logic [31:0]   set_mask, clr_mask, pend_n;

   assign alu_ready = ~alu_full;
   assign mem_ready = ~mem_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= SRC_ALU;
         alu_full  <= 1'b0;
         mem_full  <= 1'b0;
         alu_baddr <= '0;
         alu_bdata <= '0;
         mem_baddr <= '0;
         mem_bdata <= '0;
         WE3       <= 1'b0;
         A3        <= '0;
         WD3       <= '0;
         grant_src <= 1'b0;
         pending   <= '0;
      end else begin
         rr_ptr    <= rr_ptr_n;
         alu_full  <= alu_full_n;
         mem_full  <= mem_full_n;
         WE3       <= we_n;
         A3        <= a_n;
         WD3       <= wd_n;
         grant_src <= gsrc_n;
         pending   <= pend_n;
         if (alu_acc) begin
            alu_baddr <= alu_addr;
            alu_bdata <= alu_data;
         end
         if (mem_acc) begin
            mem_baddr <= mem_addr;
            mem_bdata <= mem_data;
         end
      end
   end

   always_comb begin
      // Writes to register zero finish the handshake but never fill the buffer.
      alu_acc   = alu_valid & ~alu_full & (alu_addr != '0);
      mem_acc   = mem_valid & ~mem_full & (mem_addr != '0);
      grant_alu = alu_full & (~mem_full | (rr_ptr == SRC_ALU));
      grant_mem = mem_full & ~grant_alu;

      we_n     = 1'b0;
      a_n      = A3;
      wd_n     = WD3;
      gsrc_n   = grant_src;
      rr_ptr_n = rr_ptr;
      if (grant_alu) begin
         we_n     = 1'b1;
         a_n      = alu_baddr;
         wd_n     = alu_bdata;
         gsrc_n   = 1'b0;
         rr_ptr_n = SRC_MEM;
      end else if (grant_mem) begin
         we_n     = 1'b1;
         a_n      = mem_baddr;
         wd_n     = mem_bdata;
         gsrc_n   = 1'b1;
         rr_ptr_n = SRC_ALU;
      end

      // A buffer never accepts and is granted on the same edge.
      alu_full_n = alu_full ? ~grant_alu : alu_acc;
      mem_full_n = mem_full ? ~grant_mem : mem_acc;

      set_mask = '0;
      if (alu_acc) set_mask = set_mask | (32'd1 << alu_addr);
      if (mem_acc) set_mask = set_mask | (32'd1 << mem_addr);
      clr_mask = WE3 ? (32'd1 << A3) : '0;
      // Set wins over clear; bit 0 is never tracked.
      pend_n   = ((pending & ~clr_mask) | set_mask) & ~32'd1;
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter: reset, single writes,
// contention, fairness, register zero, set/clear collision and async reset.
module tb_reg_write_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          alu_valid, alu_ready, mem_valid, mem_ready;
   logic [AW-1:0] alu_addr, mem_addr, A3;
   logic [DW-1:0] alu_data, mem_data, WD3;
   logic          WE3, grant_src;
   logic [31:0]   pending;

   int checks   = 0;
   int failures = 0;
   int n_alu    = 0;
   int n_mem    = 0;

   reg_write_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .WE3(WE3), .A3(A3), .WD3(WD3), .grant_src(grant_src), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      alu_valid = 0; alu_addr = '0; alu_data = '0;
      mem_valid = 0; mem_addr = '0; mem_data = '0;
      reset = 0;
      #1 reset = 1;
      #1;
      chk("rst_alu_rdy", alu_ready, 1);
      chk("rst_mem_rdy", mem_ready, 1);
      chk("rst_we", WE3, 0);
      chk("rst_a3", A3, 0);
      chk("rst_wd", WD3, 0);
      chk("rst_src", grant_src, 0);
      chk("rst_pend", pending, 0);
      tick; tick;
      reset = 0;

      // Single ALU write
      alu_valid = 1; alu_addr = 5; alu_data = 32'h0000_0003;
      tick; alu_valid = 0;
      chk("s1_pend", pending, 32'h20);
      chk("s1_we0", WE3, 0);
      chk("s1_rdy", alu_ready, 0);
      tick;
      chk("s1_we", WE3, 1);
      chk("s1_a3", A3, 5);
      chk("s1_wd", WD3, 3);
      chk("s1_src", grant_src, 0);
      chk("s1_rdy2", alu_ready, 1);
      chk("s1_pend2", pending, 32'h20);
      tick;
      chk("s1_we_off", WE3, 0);
      chk("s1_pend3", pending, 0);

      // Single MEM write; leaves rr_ptr at ALU
      mem_valid = 1; mem_addr = 9; mem_data = 32'h1234;
      tick; mem_valid = 0;
      chk("s2_pend", pending, 32'h200);
      chk("s2_rdy", mem_ready, 0);
      tick;
      chk("s2_we", WE3, 1);
      chk("s2_a3", A3, 9);
      chk("s2_wd", WD3, 32'h1234);
      chk("s2_src", grant_src, 1);
      tick;
      chk("s2_we_off", WE3, 0);
      chk("s2_pend2", pending, 0);
      chk("s2_a3_hold", A3, 9);
      chk("s2_src_hold", grant_src, 1);

      // Contention, ALU has priority
      alu_valid = 1; alu_addr = 1; alu_data = 32'hA;
      mem_valid = 1; mem_addr = 2; mem_data = 32'hB;
      tick; alu_valid = 0; mem_valid = 0;
      chk("c_alu_rdy", alu_ready, 0);
      chk("c_mem_rdy", mem_ready, 0);
      chk("c_pend", pending, 32'h6);
      chk("c_we0", WE3, 0);
      tick;
      chk("c1_we", WE3, 1);
      chk("c1_a3", A3, 1);
      chk("c1_wd", WD3, 32'hA);
      chk("c1_src", grant_src, 0);
      chk("c1_alu_rdy", alu_ready, 1);
      chk("c1_mem_rdy", mem_ready, 0);
      chk("c1_pend", pending, 32'h6);
      tick;
      chk("c2_we", WE3, 1);
      chk("c2_a3", A3, 2);
      chk("c2_wd", WD3, 32'hB);
      chk("c2_src", grant_src, 1);
      chk("c2_mem_rdy", mem_ready, 1);
      chk("c2_pend", pending, 32'h4);
      tick;
      chk("c3_we", WE3, 0);
      chk("c3_pend", pending, 0);

      // Fairness: both valid continuously, 8 writes each
      alu_valid = 1; alu_addr = 3; alu_data = 32'hA0A0;
      mem_valid = 1; mem_addr = 4; mem_data = 32'hB0B0;
      for (int e = 1; e <= 17; e++) begin
         tick;
         if (e == 15) alu_valid = 0;
         if (e == 16) mem_valid = 0;
         if (e == 1) chk("f_we_first", WE3, 0);
         else begin
            chk("f_we", WE3, 1);
            chk("f_src", grant_src, e % 2);
            chk("f_a3", A3, (e % 2 == 1) ? 4 : 3);
            if (grant_src) n_mem++; else n_alu++;
         end
      end
      tick;
      chk("f_idle", WE3, 0);
      chk("f_n_alu", n_alu, 8);
      chk("f_n_mem", n_mem, 8);
      chk("f_pend", pending, 0);

      // Set/clear collision on reg 7
      alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
      tick; alu_valid = 0;
      tick;
      chk("k_we", WE3, 1);
      chk("k_a3", A3, 7);
      mem_valid = 1; mem_addr = 7; mem_data = 32'h88;
      tick; mem_valid = 0;
      chk("k_pend_hold", pending, 32'h80);
      chk("k_we0", WE3, 0);
      tick;
      chk("k2_we", WE3, 1);
      chk("k2_a3", A3, 7);
      chk("k2_wd", WD3, 32'h88);
      chk("k2_src", grant_src, 1);
      chk("k2_pend", pending, 32'h80);
      tick;
      chk("k3_pend", pending, 0);
      chk("k3_we", WE3, 0);

      // Register zero is discarded
      mem_valid = 1; mem_addr = 0; mem_data = 32'hFFFF_FFFF;
      chk("z_rdy_pre", mem_ready, 1);
      tick; mem_valid = 0;
      chk("z_rdy", mem_ready, 1);
      chk("z_pend", pending, 0);
      chk("z_we", WE3, 0);
      tick;
      chk("z_we2", WE3, 0);
      tick;
      chk("z_we3", WE3, 0);
      chk("z_pend2", pending, 0);

      // Async reset while MEM buffered and a write is in flight
      alu_valid = 1; alu_addr = 11; alu_data = 32'h1;
      mem_valid = 1; mem_addr = 12; mem_data = 32'h2;
      tick; alu_valid = 0; mem_valid = 0;
      chk("r_pend", pending, 32'h1800);
      tick;
      chk("r_we", WE3, 1);
      chk("r_a3", A3, 11);
      chk("r_mem_full", mem_ready, 0);
      #2 reset = 1;
      #1;
      chk("r_async_we", WE3, 0);
      chk("r_async_pend", pending, 0);
      chk("r_async_a3", A3, 0);
      chk("r_async_wd", WD3, 0);
      chk("r_async_src", grant_src, 0);
      chk("r_async_mrdy", mem_ready, 1);
      chk("r_async_ardy", alu_ready, 1);
      tick;
      reset = 0;
      tick; tick;
      chk("r_post_we", WE3, 0);
      chk("r_post_pend", pending, 0);
      chk("r_post_mrdy", mem_ready, 1);

      // After reset ALU wins the first contention again
      alu_valid = 1; alu_addr = 13; alu_data = 32'hD;
      mem_valid = 1; mem_addr = 14; mem_data = 32'hE;
      tick; alu_valid = 0; mem_valid = 0;
      tick;
      chk("p1_src", grant_src, 0);
      chk("p1_a3", A3, 13);
      chk("p1_wd", WD3, 32'hD);
      tick;
      chk("p2_src", grant_src, 1);
      chk("p2_a3", A3, 14);
      tick;
      chk("p3_we", WE3, 0);
      chk("p3_pend", pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
